// File: rtl/mp_cache_data_banked_if.sv
// Request/response bundle for the banked cache data array.
// Request fields are shared by all ways; csb selects which ways act on them.
interface mp_cache_data_banked_if #(
  parameter int NUM_WAYS   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_GRAN  = 8
);
  localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN;

  logic [NUM_WAYS-1:0]            csb;
  logic                           web;
  logic [NUM_WMASKS-1:0]          wmask;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [DATA_WIDTH-1:0]          din;
  logic [NUM_WAYS*DATA_WIDTH-1:0] dout;
  logic [NUM_WAYS-1:0]            dout_valid;
  logic                           ready;

  modport master (
    output csb, web, wmask, addr, din,
    input  dout, dout_valid, ready
  );

  modport slave (
    input  csb, web, wmask, addr, din,
    output dout, dout_valid, ready
  );
endinterface

// File: rtl/mp_cache_data_banked.sv
// Banked cache data array: NUM_WAYS independent ways sharing one request bus.
// After reset every set of every way is zeroed one set per cycle before
// requests are accepted. Each way registers its request, commits writes one
// edge later (masked, read-first) and drives read data from its registered
// set index.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | clearing set cnt_q in every way, requests ignored, ready=0
// ST_READY | normal operation, requests accepted per selected way
module mp_cache_data_banked #(
  parameter int NUM_WAYS   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_GRAN  = 8
) (
  input logic                   clk,
  input logic                   rst,
  mp_cache_data_banked_if.slave bus
);
  localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;
  logic                  clear_en;

  logic [DATA_WIDTH-1:0] way_rdata [NUM_WAYS];
  logic                  way_valid [NUM_WAYS];

  // Init sequencer: walk every set once after reset, then hold in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Clearing is suppressed on a reset edge so the walk always restarts at set 0.
  assign clear_en  = (state_q == ST_INIT) && !rst;
  assign bus.ready = ready_q;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [NUM_WMASKS-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  accept;

    assign accept = ready_q && !bus.csb[w];

    // Request capture; an unselected way drops its write enable so a write
    // commits exactly once, while addr_q holds to keep dout stable.
    always_ff @(posedge clk) begin
      if (rst) begin
        addr_q  <= '0;
        we_q    <= 1'b0;
        wmask_q <= '0;
        din_q   <= '0;
        valid_q <= 1'b0;
      end else if (accept) begin
        addr_q  <= bus.addr;
        we_q    <= !bus.web;
        wmask_q <= bus.wmask;
        din_q   <= bus.din;
        valid_q <= bus.web;
      end else begin
        we_q    <= 1'b0;
        valid_q <= 1'b0;
      end
    end

    // Storage: zero fill during init, otherwise masked commit of the
    // registered write; a reset edge discards any pending write.
    always_ff @(posedge clk) begin
      if (clear_en) begin
        mem_q[cnt_q] <= '0;
      end else if (!rst && we_q) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
          if (wmask_q[i]) begin
            mem_q[addr_q][i*MASK_GRAN +: MASK_GRAN] <= din_q[i*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end

    assign way_rdata[w] = mem_q[addr_q];
    assign way_valid[w] = valid_q;
  end

  // Pack per-way read data and valid flags onto the shared output bus.
  always_comb begin
    bus.dout       = '0;
    bus.dout_valid = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      bus.dout[w*DATA_WIDTH +: DATA_WIDTH] = way_rdata[w];
      bus.dout_valid[w]                    = way_valid[w];
    end
  end
endmodule

// File: tb/tb_mp_cache_data_banked.sv
// Self-checking bench for mp_cache_data_banked with default parameters.
// A behavioural model (array of lines plus per-way pending write) predicts
// ready, dout_valid and dout every cycle; directed scenarios are followed by
// randomized traffic with occasional resets.
module tb_mp_cache_data_banked;
  localparam int NW = 4;
  localparam int AW = 4;
  localparam int DW = 256;
  localparam int MG = 8;
  localparam int NM = DW / MG;
  localparam int NS = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mp_cache_data_banked_if #(.NUM_WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_GRAN(MG)) bus ();

  mp_cache_data_banked #(.NUM_WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_GRAN(MG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [NW][NS];
  bit            m_ready;
  int            m_init_cycles;
  logic [AW-1:0] m_addr  [NW];
  bit            m_pend  [NW];
  logic [AW-1:0] m_paddr [NW];
  logic [NM-1:0] m_pmask [NW];
  logic [DW-1:0] m_pdin  [NW];
  bit            m_val   [NW];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  function automatic logic [DW-1:0] lane_bits(input logic [NM-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NM; i++) if (m[i]) r[i*MG +: MG] = {MG{1'b1}};
    return r;
  endfunction

  task automatic model_edge(input bit r, input logic [NW-1:0] c, input bit we_b,
                            input logic [NM-1:0] m, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    logic [DW-1:0] bm;
    if (r) begin
      m_ready       = 1'b0;
      m_init_cycles = 0;
      for (int w = 0; w < NW; w++) begin
        m_pend[w] = 1'b0;
        m_val[w]  = 1'b0;
        for (int s = 0; s < NS; s++) m_mem[w][s] = '0;
      end
    end else if (!m_ready) begin
      m_init_cycles++;
      if (m_init_cycles == NS) m_ready = 1'b1;
      for (int w = 0; w < NW; w++) begin
        m_pend[w] = 1'b0;
        m_val[w]  = 1'b0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (m_pend[w]) begin
          bm = lane_bits(m_pmask[w]);
          m_mem[w][m_paddr[w]] = (m_mem[w][m_paddr[w]] & ~bm) | (m_pdin[w] & bm);
        end
      end
      for (int w = 0; w < NW; w++) begin
        if (!c[w]) begin
          m_addr[w]  = a;
          m_pend[w]  = !we_b;
          m_paddr[w] = a;
          m_pmask[w] = m;
          m_pdin[w]  = d;
          m_val[w]   = we_b;
        end else begin
          m_pend[w] = 1'b0;
          m_val[w]  = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ready", {{(DW-1){1'b0}}, bus.ready}, {{(DW-1){1'b0}}, m_ready});
    for (int w = 0; w < NW; w++) begin
      chk($sformatf("valid_w%0d", w), {{(DW-1){1'b0}}, bus.dout_valid[w]},
          {{(DW-1){1'b0}}, m_val[w]});
      if (m_ready) chk($sformatf("dout_w%0d", w), bus.dout[w*DW +: DW], m_mem[w][m_addr[w]]);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, check at the falling edge.
  task automatic cyc(input bit r, input logic [NW-1:0] c, input bit we_b,
                     input logic [NM-1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rst       = r;
    bus.csb   = c;
    bus.web   = we_b;
    bus.wmask = m;
    bus.addr  = a;
    bus.din   = d;
    @(posedge clk);
    model_edge(r, c, we_b, m, a, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '1, 1'b1, '0, '0, '0);
  endtask

  task automatic read_set(input logic [AW-1:0] s);
    cyc(1'b0, '0, 1'b1, '0, s, '0);
  endtask

  initial begin
    bus.csb   = '1;
    bus.web   = 1'b1;
    bus.wmask = '0;
    bus.addr  = '0;
    bus.din   = '0;
    m_ready       = 1'b0;
    m_init_cycles = 0;
    for (int w = 0; w < NW; w++) begin
      m_addr[w] = '0;
      m_pend[w] = 1'b0;
      m_val[w]  = 1'b0;
      for (int s = 0; s < NS; s++) m_mem[w][s] = '0;
    end

    // Reset, then write requests during init that must be ignored.
    for (int i = 0; i < 3; i++) cyc(1'b1, '1, 1'b1, '0, '0, '0);
    for (int i = 0; i < NS; i++) cyc(1'b0, '0, 1'b0, '1, AW'($urandom), rep(8'hEE));
    idle(2);

    // Every set of every way reads zero after init.
    for (int s = 0; s < NS; s++) read_set(AW'(s));
    idle(1);

    // Partial-mask write to way 2 set 5.
    cyc(1'b0, 4'b1011, 1'b0, 32'h0000FFFF, 4'd5, rep(8'hA5));
    idle(1);
    read_set(4'd5);
    idle(1);

    // Write then immediate read of the same set.
    cyc(1'b0, 4'b1110, 1'b0, '1, 4'd3, rep(8'h11));
    cyc(1'b0, 4'b1110, 1'b1, '0, 4'd3, '0);
    idle(1);

    // Write, long gap, overlapping write to other lanes, then read.
    cyc(1'b0, 4'b1101, 1'b0, 32'h000000FF, 4'd9, rep(8'h22));
    idle(3);
    cyc(1'b0, 4'b1101, 1'b0, 32'hFF00000F, 4'd9, rep(8'h33));
    idle(1);
    read_set(4'd9);
    idle(1);

    // Reset asserted while a write is pending.
    cyc(1'b0, 4'b1110, 1'b0, '1, 4'd12, rep(8'h77));
    cyc(1'b1, '1, 1'b1, '0, '0, '0);
    idle(NS + 1);
    read_set(4'd12);
    idle(1);

    // All ways written at once.
    cyc(1'b0, 4'b0000, 1'b0, '1, 4'd7, rep(8'hFF));
    idle(1);
    read_set(4'd7);
    idle(1);

    // Randomized traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 499) == 0), NW'($urandom), 1'($urandom), NM'($urandom),
          AW'($urandom), {8{32'($urandom)}});
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
